seven_seg_scan_ctrl: RTL

- Time-multiplexing scan controller for the 8-digit seven-segment display on the Nexys A7-100T.
- Holds a 32-bit hex value (8 nibbles) and steps through the digits at a fixed refresh rate.
- Drives the digit-index (`sel[2:0]`) and nibble (`num[3:0]`) inputs of the downstream combinational segment decoder, plus a `blank` qualifier.
- Applies new values only at frame boundaries, so the display never tears mid-frame.

---
 rtl/seven_seg_scan_ctrl.sv | 118 +++++++++++
 1 files changed

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexing scan controller for an 8-digit seven-segment display.
// Steps a digit index through 0..7 at a fixed slot rate, presents the
// nibble for that digit plus a blank qualifier, and swaps in newly loaded
// values only at frame boundaries so a frame is never torn.
module seven_seg_scan_ctrl #(
    parameter int TICK_DIV   = 100000,  // clock cycles per digit slot, >= 2
    parameter int GAP_CYCLES = 2000     // blank cycles at slot start, < TICK_DIV
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] value,
    input  logic [7:0]  digit_en,
    input  logic        lz_blank,
    output logic [3:0]  num,
    output logic [2:0]  sel,
    output logic        blank,
    output logic        frame_done,
    output logic        upd_done
);

    localparam int              CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_CNT  = CNT_W'(GAP_CYCLES);

    // Per-slot phase: the anti-ghost gap, then the visible part of the slot.
    typedef enum logic {
        PH_GAP  = 1'b0,
        PH_SHOW = 1'b1
    } phase_t;

    phase_t            phase;
    logic [CNT_W-1:0]  cnt;
    logic [31:0]       disp;
    logic [31:0]       pend;
    logic              pend_vld;

    // Next-state values for the edge being computed. Every output is derived
    // from these so that num, sel and blank always describe the same slot.
    logic              slot_wrap;
    logic              frame_wrap;
    logic              apply;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [2:0]        sel_nxt;
    logic [31:0]       disp_nxt;
    phase_t            phase_nxt;
    logic [7:0]        upper_zero;
    logic              lz_sup;
    logic              blank_nxt;
    logic [3:0]        num_nxt;

    // Slot/frame sequencing and the value that will be on display next cycle.
    always_comb begin
        slot_wrap  = (cnt == CNT_LAST);
        frame_wrap = slot_wrap && (sel == 3'd7);
        apply      = frame_wrap && pend_vld;
        cnt_nxt    = slot_wrap ? '0 : cnt + 1'b1;
        // The 3-bit index wraps 7 -> 0 on its own.
        sel_nxt    = slot_wrap ? sel + 3'd1 : sel;
        disp_nxt   = apply ? pend : disp;
        phase_nxt  = (cnt_nxt < GAP_CNT) ? PH_GAP : PH_SHOW;
    end

    // Leading-zero detection: upper_zero[i] = digits 7 down to i are all zero.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        upper_zero    = '0;
        upper_zero[7] = (disp_nxt[31:28] == 4'h0);
        for (int i = 6; i >= 0; i--) begin
            upper_zero[i] = upper_zero[i+1] && (disp_nxt[4*i +: 4] == 4'h0);
        end
    end

    // Blank qualifier and nibble for the slot being entered. Digit 0 is never
    // lz-suppressed so an all-zero value still shows a single "0".
    always_comb begin
        lz_sup    = lz_blank && (sel_nxt != 3'd0) && upper_zero[sel_nxt];
        blank_nxt = (phase_nxt == PH_GAP) || !digit_en[sel_nxt] || lz_sup;
        num_nxt   = disp_nxt[{sel_nxt, 2'b00} +: 4];
    end

    // Single state register: scan position, display/pending values, outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            phase      <= PH_GAP;
            sel        <= 3'd0;
            num        <= 4'h0;
            blank      <= 1'b1;
            frame_done <= 1'b0;
            upd_done   <= 1'b0;
            disp       <= '0;
            pend       <= '0;
            pend_vld   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register here samples the pre-edge values of the others.
            cnt        <= cnt_nxt;
            phase      <= phase_nxt;
            sel        <= sel_nxt;
            num        <= num_nxt;
            blank      <= blank_nxt;
            frame_done <= frame_wrap;
            upd_done   <= apply;
            disp       <= disp_nxt;
            // A load on the boundary edge is kept for the next boundary; it
            // takes priority over the clear caused by applying the old value.
            if (load) begin
                pend     <= value;
                pend_vld <= 1'b1;
            end else if (apply) begin
                pend_vld <= 1'b0;
            end
        end
    end

endmodule
